// File: rtl/capture_controller.sv
// Logic-analyser acquisition sequencer: arm, trigger on a selected input edge,
// capture a fixed window into the sample FIFO, then unload it page by page into the SPI TX buffer.
module capture_controller #(
  parameter int FIFO_ADDR_WIDTH = 5,
  parameter int SPI_BUF_WIDTH   = 4
) (
  input  logic                                    inclk,
  input  logic                                    Reset,
  input  logic [15:0]                             inport,
  input  logic [3:0]                              cmd,
  input  logic                                    cmd_valid,
  input  logic [3:0]                              trig_sel,
  input  logic                                    trig_pos,
  output logic                                    fifo_we,
  output logic [FIFO_ADDR_WIDTH-1:0]              fifo_waddr,
  output logic [15:0]                             fifo_wdata,
  output logic [FIFO_ADDR_WIDTH-1:0]              fifo_raddr,
  input  logic [15:0]                             fifo_rdata,
  output logic                                    fifo_subaddr,
  output logic [SPI_BUF_WIDTH-1:0]                cont_addr_tx,
  output logic                                    cont_we_tx,
  output logic [7:0]                              tx_data,
  output logic [7:0]                              status,
  output logic [FIFO_ADDR_WIDTH-SPI_BUF_WIDTH:0]  page_idx
);

  localparam int SAMP_W = SPI_BUF_WIDTH - 1;
  localparam int PAGE_W = FIFO_ADDR_WIDTH - SPI_BUF_WIDTH + 1;

  localparam logic [FIFO_ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam logic [SAMP_W-1:0]          LAST_SAMPLE = '1;
  localparam logic [PAGE_W-1:0]          LAST_PAGE   = '1;

  localparam logic [3:0] CMD_ARM      = 4'h1;
  localparam logic [3:0] CMD_NEXT     = 4'h5;
  localparam logic [3:0] CMD_COMPLETE = 4'h7;

  // Encodings double as the host-visible status codes.
  typedef enum logic [2:0] {
    IDLE    = 3'h0,
    ARMED   = 3'h1,
    CAPTURE = 3'h2,
    FILL    = 3'h3,
    READY   = 3'h4,
    DONE    = 3'h6
  } state_t;

  // FILL sub-steps for one sample: present read address, emit low byte, emit high byte.
  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_LO   = 2'd1;
  localparam logic [1:0] PH_HI   = 2'd2;

  state_t                      state_reg, state_next;
  logic                        we_reg, we_next;
  logic [FIFO_ADDR_WIDTH-1:0]  waddr_reg, waddr_next;
  logic [15:0]                 wdata_reg, wdata_next;
  logic [PAGE_W-1:0]           page_reg, page_next;
  logic [SAMP_W-1:0]           samp_reg, samp_next;
  logic [1:0]                  phase_reg, phase_next;
  logic                        prev_bit_reg, prev_bit_next;
  logic                        seed_reg, seed_next;
  logic [3:0]                  sel_reg;
  logic                        pos_reg;

  logic cur_bit;
  logic cfg_changed;
  logic fire;
  logic is_arm, is_next, is_complete;

  assign is_arm      = cmd_valid && (cmd == CMD_ARM);
  assign is_next     = cmd_valid && (cmd == CMD_NEXT);
  assign is_complete = cmd_valid && (cmd == CMD_COMPLETE);

  // A select/polarity change only re-seeds history; it never fires in the cycle it is seen.
  assign cur_bit     = inport[trig_sel];
  assign cfg_changed = (trig_sel != sel_reg) || (trig_pos != pos_reg);
  assign fire        = (state_reg == ARMED) && !seed_reg && !cfg_changed &&
                       (prev_bit_reg != cur_bit) && (cur_bit == trig_pos);

  always_comb begin
    state_next    = state_reg;
    we_next       = 1'b0;
    waddr_next    = waddr_reg;
    wdata_next    = wdata_reg;
    page_next     = page_reg;
    samp_next     = samp_reg;
    phase_next    = phase_reg;
    prev_bit_next = prev_bit_reg;
    seed_next     = 1'b0;

    if (is_complete) begin
      state_next    = IDLE;
      waddr_next    = '0;
      wdata_next    = '0;
      page_next     = '0;
      samp_next     = '0;
      phase_next    = PH_ADDR;
      prev_bit_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_arm) begin
            state_next = ARMED;
            waddr_next = '0;
            seed_next  = 1'b1;
          end
        end
        ARMED: begin
          prev_bit_next = cur_bit;
          if (fire) begin
            state_next = CAPTURE;
            we_next    = 1'b1;
            waddr_next = '0;
            wdata_next = inport;
          end
        end
        CAPTURE: begin
          if (waddr_reg == LAST_ADDR) begin
            state_next = FILL;
            page_next  = '0;
            samp_next  = '0;
            phase_next = PH_ADDR;
          end else begin
            we_next    = 1'b1;
            waddr_next = waddr_reg + 1'b1;
            wdata_next = inport;
          end
        end
        FILL: begin
          case (phase_reg)
            PH_ADDR: phase_next = PH_LO;
            PH_LO:   phase_next = PH_HI;
            default: begin
              phase_next = PH_ADDR;
              if (samp_reg == LAST_SAMPLE) begin
                state_next = READY;
              end else begin
                samp_next = samp_reg + 1'b1;
              end
            end
          endcase
        end
        READY: begin
          if (is_next) begin
            if (page_reg == LAST_PAGE) begin
              state_next = DONE;
            end else begin
              state_next = FILL;
              page_next  = page_reg + 1'b1;
              samp_next  = '0;
              phase_next = PH_ADDR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge inclk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      page_reg     <= '0;
      samp_reg     <= '0;
      phase_reg    <= PH_ADDR;
      prev_bit_reg <= 1'b0;
      seed_reg     <= 1'b0;
      sel_reg      <= '0;
      pos_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      we_reg       <= we_next;
      waddr_reg    <= waddr_next;
      wdata_reg    <= wdata_next;
      page_reg     <= page_next;
      samp_reg     <= samp_next;
      phase_reg    <= phase_next;
      prev_bit_reg <= prev_bit_next;
      seed_reg     <= seed_next;
      sel_reg      <= trig_sel;
      pos_reg      <= trig_pos;
    end
  end

  // Byte outputs follow the FIFO's registered read data, so they are gated off outside byte phases.
  assign fifo_we      = we_reg;
  assign fifo_waddr   = waddr_reg;
  assign fifo_wdata   = wdata_reg;
  assign fifo_raddr   = {page_reg, samp_reg};
  assign page_idx     = page_reg;
  assign status       = {5'd0, state_reg};
  assign cont_we_tx   = (state_reg == FILL) && (phase_reg != PH_ADDR);
  assign fifo_subaddr = cont_we_tx && (phase_reg == PH_HI);
  assign cont_addr_tx = cont_we_tx ? {samp_reg, fifo_subaddr} : '0;
  assign tx_data      = !cont_we_tx ? 8'h00 :
                        (fifo_subaddr ? fifo_rdata[15:8] : fifo_rdata[7:0]);

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: a FIFO model plus scoreboard queues of
// expected FIFO writes and TX bytes, compared as the controller produces them.
`timescale 1ns/1ps
module tb_capture_controller;
  localparam int FAW   = 5;
  localparam int SBW   = 4;
  localparam int DEPTH = 32;
  localparam int SPP   = 8;

  localparam logic [3:0] ARM      = 4'h1;
  localparam logic [3:0] NEXT     = 4'h5;
  localparam logic [3:0] COMPLETE = 4'h7;

  logic            inclk = 1'b0;
  logic            Reset = 1'b1;
  logic [15:0]     inport = 16'h0;
  logic [3:0]      cmd = 4'h0;
  logic            cmd_valid = 1'b0;
  logic [3:0]      trig_sel = 4'h0;
  logic            trig_pos = 1'b0;
  logic            fifo_we;
  logic [FAW-1:0]  fifo_waddr;
  logic [15:0]     fifo_wdata;
  logic [FAW-1:0]  fifo_raddr;
  logic [15:0]     fifo_rdata = 16'h0;
  logic            fifo_subaddr;
  logic [SBW-1:0]  cont_addr_tx;
  logic            cont_we_tx;
  logic [7:0]      tx_data;
  logic [7:0]      status;
  logic [1:0]      page_idx;

  int errors = 0;
  int checks = 0;
  bit count_en = 1'b0;

  logic [15:0] fifo_mem [DEPTH];
  logic [20:0] wr_obs[$], exp_wr[$];
  logic [11:0] tx_obs[$], exp_tx[$];
  logic [7:0]  status_obs[$];
  logic [7:0]  last_status = 8'h00;
  int          fill_cnt = 0;

  always #5 inclk = ~inclk;

  capture_controller #(.FIFO_ADDR_WIDTH(FAW), .SPI_BUF_WIDTH(SBW)) dut (
    .inclk(inclk), .Reset(Reset), .inport(inport), .cmd(cmd), .cmd_valid(cmd_valid),
    .trig_sel(trig_sel), .trig_pos(trig_pos), .fifo_we(fifo_we), .fifo_waddr(fifo_waddr),
    .fifo_wdata(fifo_wdata), .fifo_raddr(fifo_raddr), .fifo_rdata(fifo_rdata),
    .fifo_subaddr(fifo_subaddr), .cont_addr_tx(cont_addr_tx), .cont_we_tx(cont_we_tx),
    .tx_data(tx_data), .status(status), .page_idx(page_idx)
  );

  initial for (int i = 0; i < DEPTH; i++) fifo_mem[i] = 16'h0;

  // Sample FIFO with one-cycle synchronous read.
  always @(posedge inclk) begin
    if (fifo_we) fifo_mem[fifo_waddr] <= fifo_wdata;
    fifo_rdata <= fifo_mem[fifo_raddr];
  end

  // Observed traffic, sampled just after each rising edge.
  always @(posedge inclk) begin
    #1;
    if (fifo_we) wr_obs.push_back({fifo_waddr, fifo_wdata});
    if (cont_we_tx) tx_obs.push_back({cont_addr_tx, tx_data});
    if (status != last_status) begin
      status_obs.push_back(status);
      last_status <= status;
    end
    if (status == 8'h03) fill_cnt <= fill_cnt + 1;
  end

  task automatic tick();
    @(negedge inclk);
    if (count_en) inport = inport + 16'd1;
  endtask

  task automatic send_cmd(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd = 4'h0;
  endtask

  task automatic wait_status(input logic [7:0] code, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (status == code) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_page(input int page);
    logic [15:0] v;
    logic [3:0]  a;
    for (int s = 0; s < SPP; s++) begin
      v = 16'(8 + page * SPP + s);
      a = 4'(2 * s);
      exp_tx.push_back({a, v[7:0]});
      a = 4'(2 * s + 1);
      exp_tx.push_back({a, v[15:8]});
    end
  endtask

  task automatic arm_on_counter();
    trig_sel = 4'd3;
    trig_pos = 1'b1;
    inport = 16'h0;
    count_en = 1'b1;
    while (inport != 16'd2) tick();
    send_cmd(ARM);
  endtask

  task automatic drain_tx(input string name);
    logic [11:0] e, o;
    while (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      checks++;
      if (tx_obs.size() == 0) begin
        errors++;
        $display("FAIL %s: tx byte missing, required addr/data %h", name, e);
      end else begin
        o = tx_obs.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: tx addr/data got %h required %h", name, o, e);
        end
      end
    end
    checks++;
    if (tx_obs.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d extra tx bytes", name, tx_obs.size());
    end
    tx_obs.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h required 00", status); end
    checks++;
    if ({fifo_we, cont_we_tx, fifo_subaddr} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b required 000", {fifo_we, cont_we_tx, fifo_subaddr});
    end
    checks++;
    if ({fifo_waddr, fifo_wdata, fifo_raddr, cont_addr_tx, tx_data, page_idx} !== '0) begin
      errors++;
      $display("FAIL reset_buses: waddr=%h wdata=%h raddr=%h txaddr=%h txdata=%h page=%h required 0",
               fifo_waddr, fifo_wdata, fifo_raddr, cont_addr_tx, tx_data, page_idx);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_capture();
    bit ok;
    logic [20:0] e, o;
    logic [7:0] seq [4];
    int f0;
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04;
    status_obs.delete(); wr_obs.delete(); tx_obs.delete(); exp_wr.delete(); exp_tx.delete();
    f0 = fill_cnt;
    arm_on_counter();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (inport >= 16'd8 && inport < 16'd40) exp_wr.push_back({5'(inport - 16'd8), inport});
      if (inport >= 16'd8 && inport < 16'd16) begin
        exp_tx.push_back({4'(2 * (inport - 16'd8)), inport[7:0]});
        exp_tx.push_back({4'(2 * (inport - 16'd8) + 1), inport[15:8]});
      end
      if (status == 8'h04) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL capture_timeout: status %h required 04", status); end
    checks++;
    if (wr_obs.size() != DEPTH) begin
      errors++; $display("FAIL capture_count: got %0d writes required %0d", wr_obs.size(), DEPTH);
    end
    while (exp_wr.size() > 0 && wr_obs.size() > 0) begin
      e = exp_wr.pop_front();
      o = wr_obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL capture_write: addr/data got %h required %h", o, e); end
    end
    checks++;
    if (status_obs.size() != 4) begin
      errors++; $display("FAIL status_seq_len: got %0d changes required 4", status_obs.size());
    end
    for (int i = 0; i < 4 && i < status_obs.size(); i++) begin
      checks++;
      if (status_obs[i] !== seq[i]) begin
        errors++; $display("FAIL status_seq[%0d]: got %h required %h", i, status_obs[i], seq[i]);
      end
    end
    checks++;
    if (fill_cnt - f0 != 24) begin errors++; $display("FAIL fill_cycles: got %0d required 24", fill_cnt - f0); end
    checks++;
    if (page_idx !== 2'd0) begin errors++; $display("FAIL page0_idx: got %0d required 0", page_idx); end
    drain_tx("page0");
  endtask

  task automatic test_pages();
    bit ok;
    int f0;
    for (int p = 1; p < 4; p++) begin
      push_page(p);
      f0 = fill_cnt;
      send_cmd(NEXT);
      wait_status(8'h04, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL page%0d_timeout: status %h required 04", p, status); end
      checks++;
      if (page_idx !== 2'(p)) begin errors++; $display("FAIL page%0d_idx: got %0d required %0d", p, page_idx, p); end
      checks++;
      if (fill_cnt - f0 != 24) begin
        errors++; $display("FAIL page%0d_cycles: got %0d required 24", p, fill_cnt - f0);
      end
      drain_tx($sformatf("page%0d", p));
    end
    send_cmd(NEXT);
    checks++;
    if (status !== 8'h06) begin errors++; $display("FAIL done_status: got %h required 06", status); end
    repeat (5) tick();
    send_cmd(NEXT);
    tick();
    checks++;
    if (status !== 8'h06 || tx_obs.size() != 0) begin
      errors++; $display("FAIL done_hold: status %h tx writes %0d required 06 and 0", status, tx_obs.size());
    end
  endtask

  task automatic test_falling_trigger();
    bit ok;
    int zero_addr;
    logic [20:0] o;
    send_cmd(COMPLETE);
    checks++;
    if (status !== 8'h00) begin errors++; $display("FAIL complete_done: got %h required 00", status); end
    count_en = 1'b0;
    trig_sel = 4'd0;
    trig_pos = 1'b0;
    inport = 16'h0001;
    wr_obs.delete(); exp_wr.delete();
    send_cmd(ARM);
    repeat (9) tick();
    checks++;
    if (status !== 8'h01 || wr_obs.size() != 0) begin
      errors++; $display("FAIL fall_pre: status %h writes %0d required 01 and 0", status, wr_obs.size());
    end
    inport = 16'h0000;
    exp_wr.push_back({5'd0, 16'h0000});
    wait_status(8'h03, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fall_timeout: status %h required 03", status); end
    checks++;
    if (wr_obs.size() != DEPTH) begin
      errors++; $display("FAIL fall_count: got %0d writes required %0d", wr_obs.size(), DEPTH);
    end
    zero_addr = 0;
    foreach (wr_obs[i]) if (wr_obs[i][20:16] == 5'd0) zero_addr++;
    checks++;
    if (zero_addr != 1) begin errors++; $display("FAIL fall_single: got %0d triggers required 1", zero_addr); end
    if (wr_obs.size() > 0) begin
      o = wr_obs[0];
      checks++;
      if (o !== exp_wr[0]) begin errors++; $display("FAIL fall_addr0: got %h required %h", o, exp_wr[0]); end
    end
    exp_wr.delete();

    send_cmd(COMPLETE);
    wr_obs.delete();
    inport = 16'h0001;
    send_cmd(ARM);
    repeat (50) tick();
    checks++;
    if (status !== 8'h01 || wr_obs.size() != 0) begin
      errors++; $display("FAIL no_edge: status %h writes %0d required 01 and 0", status, wr_obs.size());
    end
    trig_sel = 4'd1;
    repeat (10) tick();
    checks++;
    if (status !== 8'h01 || wr_obs.size() != 0) begin
      errors++; $display("FAIL sel_reseed: status %h writes %0d required 01 and 0", status, wr_obs.size());
    end
    send_cmd(COMPLETE);
  endtask

  task automatic test_abort();
    bit ok;
    logic [20:0] o;
    int f0;
    wr_obs.delete();
    arm_on_counter();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_we && fifo_waddr == 5'd10) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach: waddr %0d required 10", fifo_waddr); end
    send_cmd(COMPLETE);
    checks++;
    if (status !== 8'h00 || fifo_we !== 1'b0) begin
      errors++; $display("FAIL abort_capture: status %h we %b required 00 and 0", status, fifo_we);
    end
    tick();
    checks++;
    if (wr_obs.size() != 11) begin errors++; $display("FAIL abort_writes: got %0d required 11", wr_obs.size()); end
    else begin
      o = wr_obs[10];
      checks++;
      if (o[20:16] !== 5'd10) begin errors++; $display("FAIL abort_last: got addr %0d required 10", o[20:16]); end
    end

    tx_obs.delete();
    f0 = fill_cnt;
    arm_on_counter();
    wait_status(8'h03, 100, ok);
    repeat (4) tick();
    send_cmd(NEXT);
    wait_status(8'h04, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_next_timeout: status %h required 04", status); end
    push_page(0);
    checks++;
    if (page_idx !== 2'd0 || fill_cnt - f0 != 24) begin
      errors++; $display("FAIL fill_next_skip: page %0d cycles %0d required 0 and 24", page_idx, fill_cnt - f0);
    end
    drain_tx("fill_next");
    send_cmd(COMPLETE);
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    logic [20:0] o;
    arm_on_counter();
    wait_status(8'h03, 100, ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cont_we_tx && cont_addr_tx == 4'd5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_reach: byte 5 not seen, txaddr %h", cont_addr_tx); end
    Reset = 1'b1;
    tick();
    checks++;
    if ({fifo_we, fifo_waddr, fifo_wdata, fifo_raddr, fifo_subaddr, cont_addr_tx, cont_we_tx,
         tx_data, status, page_idx} !== '0) begin
      errors++;
      $display("FAIL rst_fill: we=%b waddr=%h wdata=%h raddr=%h sub=%b txa=%h txwe=%b txd=%h st=%h pg=%h required 0",
               fifo_we, fifo_waddr, fifo_wdata, fifo_raddr, fifo_subaddr, cont_addr_tx, cont_we_tx,
               tx_data, status, page_idx);
    end
    Reset = 1'b0;
    tick();
    wr_obs.delete(); tx_obs.delete();
    arm_on_counter();
    wait_status(8'h04, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_rearm_timeout: status %h required 04", status); end
    checks++;
    if (wr_obs.size() != DEPTH) begin
      errors++; $display("FAIL rst_rearm_count: got %0d required %0d", wr_obs.size(), DEPTH);
    end else begin
      o = wr_obs[0];
      checks++;
      if (o !== {5'd0, 16'h0008}) begin errors++; $display("FAIL rst_rearm_first: got %h required 00008", o); end
    end
    tx_obs.delete();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_pages();
    test_falling_trigger();
    test_abort();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
